// File: rtl/inst_rom_if.sv
// Fetch-request and program-load bundle between the IF stage / loader and the instruction ROM.
// The master side issues fetches and loads; the slave side is the ROM controller.
interface inst_rom_if #(
    parameter int DEPTH_LOG2 = 8
);
    logic                  romCe;
    logic [31:0]           pc;
    logic [31:0]           inst;
    logic                  instValid;
    logic                  addrErr;
    logic                  ready;
    logic                  loadEn;
    logic                  loadLast;
    logic [31:0]           loadData;
    logic [DEPTH_LOG2:0]   loadCount;
    logic                  loadOvf;

    modport master (
        output romCe, pc, loadEn, loadLast, loadData,
        input  inst, instValid, addrErr, ready, loadCount, loadOvf
    );

    modport slave (
        input  romCe, pc, loadEn, loadLast, loadData,
        output inst, instValid, addrErr, ready, loadCount, loadOvf
    );
endinterface

// File: rtl/inst_rom_ctrl.sv
// Instruction ROM responder: filled once through the load port, then serves fetches with one-cycle latency.
//   state | meaning
//   IDLE  | empty after reset, waiting for the first program word
//   LOAD  | program partially loaded, fetches ignored
//   RUN   | program loaded, fetches served, further loads only flag overflow
module inst_rom_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic      clk,
    input  logic      rst,
    inst_rom_if.slave bus
);
    localparam int                  DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] C_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] C_LAST = C_FULL - 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_wr_en;
    logic                w_ovf_set;

    logic [31:0]         r_mem [DEPTH];
    logic [DEPTH_LOG2:0] r_load_count;
    logic [31:0]         r_inst;
    logic                r_inst_valid;
    logic                r_addr_err;
    logic                r_load_ovf;

    logic                w_borrow;
    logic [29:0]         w_idx;
    logic                w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_ovf_set   = 1'b0;
        case (r_state)
            IDLE, LOAD: begin
                if (bus.loadEn) begin
                    w_wr_en = 1'b1;
                    if (bus.loadLast || (r_load_count == C_LAST)) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_state_nxt = LOAD;
                    end
                end
            end
            RUN: begin
                if (bus.loadEn && (r_load_count == C_FULL)) begin
                    w_ovf_set = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Word offset from base, with the borrow out of the byte bits folded in so
    // the whole of (pc - BASE_ADDR) >> 2 is formed without a 32-bit temporary.
    assign w_borrow = (bus.pc[1:0] < BASE_ADDR[1:0]);
    assign w_idx    = bus.pc[31:2] - BASE_ADDR[31:2] - {29'd0, w_borrow};
    assign w_hit    = (bus.pc >= BASE_ADDR) && (bus.pc[1:0] == 2'b00) &&
                      ({2'b00, w_idx} < {{(31 - DEPTH_LOG2){1'b0}}, r_load_count});

    always_ff @(posedge clk) begin
        if (w_wr_en && !rst) begin
            r_mem[r_load_count[DEPTH_LOG2-1:0]] <= bus.loadData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_count <= '0;
            r_inst       <= 32'd0;
            r_inst_valid <= 1'b0;
            r_addr_err   <= 1'b0;
            r_load_ovf   <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_load_count <= r_load_count + 1'b1;
            end
            if (w_ovf_set) begin
                r_load_ovf <= 1'b1;
            end
            if ((r_state == RUN) && bus.romCe) begin
                r_inst_valid <= 1'b1;
                if (w_hit) begin
                    r_inst     <= r_mem[w_idx[DEPTH_LOG2-1:0]];
                    r_addr_err <= 1'b0;
                end else begin
                    r_inst     <= NOP_WORD;
                    r_addr_err <= 1'b1;
                end
            end else begin
                r_inst       <= 32'd0;
                r_inst_valid <= 1'b0;
                r_addr_err   <= 1'b0;
            end
        end
    end

    assign bus.inst      = r_inst;
    assign bus.instValid = r_inst_valid;
    assign bus.addrErr   = r_addr_err;
    assign bus.ready     = (r_state == RUN);
    assign bus.loadCount = r_load_count;
    assign bus.loadOvf   = r_load_ovf;
endmodule

// File: tb/tb_inst_rom_ctrl.sv
// Bench for inst_rom_ctrl: a word-array reference model checked every cycle,
// plus directed literal expectations along the test plan.
module tb_inst_rom_ctrl;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          NW   = 256;

    logic clk;
    logic rst;
    int   n_vec  = 0;
    int   n_miss = 0;

    inst_rom_if #(.DEPTH_LOG2(8)) bus ();

    inst_rom_ctrl #(
        .BASE_ADDR (BASE),
        .DEPTH_LOG2(8),
        .NOP_WORD  (32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a program array plus a word count; the ROM serves
    // fetches once the program is complete.
    logic [31:0] m_mem [NW];
    int          m_count   = 0;
    bit          m_ready   = 0;
    bit          m_ovf     = 0;
    bit          m_started = 0;
    logic [31:0] e_inst;
    logic        e_valid, e_err;

    always @(posedge clk) begin
        longint p;
        m_started = 1;
        if (rst) begin
            m_count = 0; m_ready = 0; m_ovf = 0;
            e_inst = 0; e_valid = 0; e_err = 0;
        end else begin
            p = longint'(bus.pc);
            if (m_ready && bus.romCe) begin
                e_valid = 1;
                if (p >= longint'(BASE) && (p % 4) == 0 && ((p - longint'(BASE)) / 4) < m_count) begin
                    e_inst = m_mem[(p - longint'(BASE)) / 4];
                    e_err  = 0;
                end else begin
                    e_inst = 32'h0;
                    e_err  = 1;
                end
            end else begin
                e_inst = 0; e_valid = 0; e_err = 0;
            end
            if (!m_ready && bus.loadEn) begin
                m_mem[m_count] = bus.loadData;
                m_count++;
                if (bus.loadLast || m_count == NW) m_ready = 1;
            end else if (m_ready && bus.loadEn && m_count == NW) begin
                m_ovf = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("model.inst",      bus.inst,              e_inst);
            chk("model.instValid", 32'(bus.instValid),    32'(e_valid));
            chk("model.addrErr",   32'(bus.addrErr),      32'(e_err));
            chk("model.ready",     32'(bus.ready),        32'(m_ready));
            chk("model.loadCount", 32'(bus.loadCount),    32'(m_count));
            chk("model.loadOvf",   32'(bus.loadOvf),      32'(m_ovf));
        end
    end

    task automatic step(input bit r, input bit ce, input logic [31:0] p,
                        input bit le, input bit ll, input logic [31:0] d);
        rst          = r;
        bus.romCe    = ce;
        bus.pc       = p;
        bus.loadEn   = le;
        bus.loadLast = ll;
        bus.loadData = d;
        @(negedge clk);
    endtask

    task automatic fetch_expect(input logic [31:0] p, input logic [31:0] inst, input bit err);
        step(0, 1, p, 0, 0, 0);
        chk($sformatf("lit.inst@%h", p),  bus.inst, inst);
        chk($sformatf("lit.valid@%h", p), 32'(bus.instValid), 32'd1);
        chk($sformatf("lit.err@%h", p),   32'(bus.addrErr), 32'(err));
    endtask

    initial begin
        rst = 1; bus.romCe = 1; bus.pc = BASE; bus.loadEn = 1; bus.loadLast = 0; bus.loadData = 32'h1234_5678;

        // reset held with fetch and load requests present
        step(1, 1, BASE, 1, 0, 32'h1234_5678);
        step(1, 1, BASE, 1, 0, 32'h1234_5678);
        chk("rst.inst",      bus.inst, 32'd0);
        chk("rst.instValid", 32'(bus.instValid), 32'd0);
        chk("rst.addrErr",   32'(bus.addrErr), 32'd0);
        chk("rst.ready",     32'(bus.ready), 32'd0);
        chk("rst.loadCount", 32'(bus.loadCount), 32'd0);
        chk("rst.loadOvf",   32'(bus.loadOvf), 32'd0);

        // 4-word program, fetch requests interleaved during the load
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, BASE, 1, (i == 4), 32'h2001_0000 + 32'(i));
            if (i < 4) chk("load.ready_low", 32'(bus.ready), 32'd0);
            chk("load.valid_low", 32'(bus.instValid), 32'd0);
        end
        chk("load4.ready", 32'(bus.ready), 32'd1);
        chk("load4.count", 32'(bus.loadCount), 32'd4);

        fetch_expect(32'h100, 32'h2001_0001, 0);
        fetch_expect(32'h104, 32'h2001_0002, 0);
        fetch_expect(32'h108, 32'h2001_0003, 0);
        fetch_expect(32'h10C, 32'h2001_0004, 0);
        fetch_expect(32'h110, 32'h0, 1);
        fetch_expect(32'h102, 32'h0, 1);
        fetch_expect(32'h0FC, 32'h0, 1);
        fetch_expect(32'hFFFF_FFFC, 32'h0, 1);
        step(0, 0, 32'h100, 1, 0, 32'hFFFF_0000);
        chk("idle.valid", 32'(bus.instValid), 32'd0);
        chk("run.load_ignored_ovf", 32'(bus.loadOvf), 32'd0);
        fetch_expect(32'h100, 32'h2001_0001, 0);

        // reset while a request is in flight
        step(1, 1, 32'h104, 0, 0, 0);
        chk("rst_run.valid", 32'(bus.instValid), 32'd0);

        // fill the whole array without loadLast
        for (int i = 0; i < NW; i++) begin
            step(0, 0, 0, 1, 0, 32'h3000_0000 + 32'(i));
            if (i == NW - 2) chk("full.ready_low", 32'(bus.ready), 32'd0);
        end
        chk("full.ready", 32'(bus.ready), 32'd1);
        chk("full.count", 32'(bus.loadCount), 32'd256);
        step(0, 0, 0, 1, 1, 32'hDEAD_BEEF);
        chk("full.ovf", 32'(bus.loadOvf), 32'd1);
        fetch_expect(32'h100, 32'h3000_0000, 0);
        fetch_expect(32'h4FC, 32'h3000_00FF, 0);
        fetch_expect(32'h500, 32'h0, 1);
        fetch_expect(32'h280, 32'h3000_0060, 0);

        // reset in the middle of a load
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 32'h5555_0000);
        step(0, 0, 0, 1, 0, 32'h5555_0001);
        step(1, 0, 0, 1, 0, 32'h5555_0002);
        chk("midrst.count0", 32'(bus.loadCount), 32'd0);
        step(0, 1, 32'h100, 1, 1, 32'hABCD_0000);
        chk("midrst.count", 32'(bus.loadCount), 32'd1);
        chk("midrst.ready", 32'(bus.ready), 32'd1);
        chk("midrst.ovf",   32'(bus.loadOvf), 32'd0);
        fetch_expect(32'h100, 32'hABCD_0000, 0);
        fetch_expect(32'h104, 32'h0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("end.valid", 32'(bus.instValid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
